// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared CPU pipeline package.
// Holds the hazard controller FSM state encoding, its parameter defaults
// (timeout length, event counter width) and the pipeline control-field widths
// that the other pipeline blocks use.
package pipeline_hazard_ctrl_pkg;

    // Pipeline control-field widths
    localparam int REG_IDX_W = 5;   // architectural register index
    localparam int ALU_OP_W  = 4;   // ALU operation select in ID/EX
    localparam int WB_SEL_W  = 2;   // write-back source select

    // Hazard controller parameter defaults
    localparam int TIMEOUT_DEF = 16;   // consecutive busy cycles before ERROR
    localparam int CNT_W_DEF   = 16;   // event counter width

    // Hazard controller FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_FREEZE = 2'b01,
        ST_ERROR  = 2'b10
    } hz_state_e;

endpackage : pipeline_hazard_ctrl_pkg

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: purely combinational load-use hazard comparator.
// Flags when the instruction in ID reads a register that the load currently
// in ID/EX will write. Register 0 is hard-wired to zero, so it never hazards.
// Ports:
//   id_rs1, id_rs2         source register indices of the ID instruction
//   id_use_rs1, id_use_rs2 ID instruction actually reads rs1 / rs2
//   ex_rd                  destination index in ID/EX
//   ex_memread             ID/EX instruction is a load
//   load_use               hazard detected
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_memread,
    output logic                 load_use
);

    logic rd_nonzero_s;
    logic rs1_match_s;
    logic rs2_match_s;

    // Compare each used source index against the load destination
    always_comb begin
        rd_nonzero_s = (ex_rd != {REG_IDX_W{1'b0}});
        rs1_match_s  = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_match_s  = id_use_rs2 && (id_rs2 == ex_rd);
        load_use     = ex_memread && rd_nonzero_s && (rs1_match_s || rs2_match_s);
    end

endmodule : load_use_detect

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage pipeline stall/flush/freeze controller.
// Decisions are combinational from the FSM state and current inputs, so every
// control takes effect at the next rising edge.
// Priority: ERROR > dmem_busy freeze > taken branch flush > load-use stall.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   id_rs1/id_rs2/id_use_rs1/2      ID source operands and use flags
//   ex_rd, ex_memread               ID/EX destination and load flag
//   branch_taken                    taken branch resolved in EX
//   dmem_busy                       data memory not ready
//   pc_en, pc_sel_target            PC enable / branch target select
//   ifid_en/flush, idex_en/flush    IF/ID and ID/EX hold and bubble controls
//   exmem_en, memwb_en              EX/MEM and MEM/WB hold controls
//   halt                            sticky timeout error
//   stall_cnt, flush_cnt            saturating event counters
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_memread,
    input  logic                 branch_taken,
    input  logic                 dmem_busy,
    output logic                 pc_en,
    output logic                 pc_sel_target,
    output logic                 ifid_en,
    output logic                 ifid_flush,
    output logic                 idex_en,
    output logic                 idex_flush,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 halt,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int                TCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);
    localparam logic [TCNT_W-1:0] TCNT_ZERO = TCNT_W'(0);

    hz_state_e          state_r;
    hz_state_e          state_nxt_s;
    logic [TCNT_W-1:0]  tcnt_r;       // busy cycles seen before the current one
    logic [TCNT_W-1:0]  tcnt_nxt_s;
    logic               load_use_s;
    logic               do_stall_s;
    logic               do_flush_s;

    // Saturating increment: holds at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    load_use_detect u_load_use_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_memread (ex_memread),
        .load_use   (load_use_s)
    );

    // Next-state and control decode; RUN rules also apply on the cycle a
    // FREEZE releases, so a held branch is flushed (and counted) right then
    always_comb begin
        pc_en         = 1'b1;
        pc_sel_target = 1'b0;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b0;
        idex_en       = 1'b1;
        idex_flush    = 1'b0;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        halt          = 1'b0;
        do_stall_s    = 1'b0;
        do_flush_s    = 1'b0;
        state_nxt_s   = state_r;
        tcnt_nxt_s    = tcnt_r;

        if (reset) begin
            // Hold RUN/no-event controls while reset is asserted
            state_nxt_s = ST_RUN;
            tcnt_nxt_s  = TCNT_ZERO;
        end else begin
            case (state_r)
                ST_RUN, ST_FREEZE: begin
                    if (dmem_busy) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_en  = 1'b0;
                        exmem_en = 1'b0;
                        memwb_en = 1'b0;
                        // tcnt_r is 0 in RUN, so this also covers TIMEOUT=1
                        if (tcnt_r == TCNT_LAST) begin
                            state_nxt_s = ST_ERROR;
                            tcnt_nxt_s  = tcnt_r;
                        end else begin
                            state_nxt_s = ST_FREEZE;
                            tcnt_nxt_s  = tcnt_r + TCNT_ONE;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                        tcnt_nxt_s  = TCNT_ZERO;
                        if (branch_taken) begin
                            pc_sel_target = 1'b1;
                            ifid_flush    = 1'b1;
                            idex_flush    = 1'b1;
                            do_flush_s    = 1'b1;
                        end else if (load_use_s) begin
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            idex_flush = 1'b1;
                            do_stall_s = 1'b1;
                        end else begin
                            do_stall_s = 1'b0;
                        end
                    end
                end
                ST_ERROR: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                    halt     = 1'b1;
                end
                default: begin
                    // Illegal encoding: freeze the pipe for a cycle and recover
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_en    = 1'b0;
                    state_nxt_s = ST_RUN;
                    tcnt_nxt_s  = TCNT_ZERO;
                end
            endcase
        end
    end

    // FSM state and timeout counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
            tcnt_r  <= TCNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            tcnt_r  <= tcnt_nxt_s;
        end
    end

    // Saturating stall / flush event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= {CNT_W{1'b0}};
            flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (do_stall_s) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (do_flush_s) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances share stimulus:
// the default configuration and one with 2-bit counters for saturation.
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 16;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memread, branch_taken, dmem_busy;

    logic        a_pc_en, a_sel, a_ifid_en, a_ifid_fl, a_idex_en, a_idex_fl, a_exmem_en, a_memwb_en, a_halt;
    logic [15:0] a_stall, a_flush;
    logic        b_pc_en, b_sel, b_ifid_en, b_ifid_fl, b_idex_en, b_idex_fl, b_exmem_en, b_memwb_en, b_halt;
    logic [1:0]  b_stall, b_flush;

    int checks   = 0;
    int failures = 0;

    // Reference model state: consecutive busy cycles, error flag, raw event counts
    int m_busy  = 0;
    bit m_err   = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    pipeline_hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_en(a_pc_en), .pc_sel_target(a_sel), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_fl),
        .idex_en(a_idex_en), .idex_flush(a_idex_fl), .exmem_en(a_exmem_en), .memwb_en(a_memwb_en),
        .halt(a_halt), .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    pipeline_hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_en(b_pc_en), .pc_sel_target(b_sel), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_fl),
        .idex_en(b_idex_en), .idex_flush(b_idex_fl), .exmem_en(b_exmem_en), .memwb_en(b_memwb_en),
        .halt(b_halt), .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    wire [8:0] ctl_a = {a_pc_en, a_sel, a_ifid_en, a_ifid_fl, a_idex_en, a_idex_fl, a_exmem_en, a_memwb_en, a_halt};
    wire [8:0] ctl_b = {b_pc_en, b_sel, b_ifid_en, b_ifid_fl, b_idex_en, b_idex_fl, b_exmem_en, b_memwb_en, b_halt};

    // Control vectors {pc_en, sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halt}
    localparam logic [8:0] C_IDLE   = 9'b1_0_1_0_1_0_1_1_0;
    localparam logic [8:0] C_STALL  = 9'b0_0_0_0_1_1_1_1_0;
    localparam logic [8:0] C_BRANCH = 9'b1_1_1_1_1_1_1_1_0;
    localparam logic [8:0] C_FREEZE = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] C_ERROR  = 9'b0_0_0_0_0_0_0_0_1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit model_load_use();
        return ex_memread && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    endfunction

    function automatic logic [8:0] model_ctl();
        if (reset)             return C_IDLE;
        if (m_err)             return C_ERROR;
        if (dmem_busy)         return C_FREEZE;
        if (branch_taken)      return C_BRANCH;
        if (model_load_use())  return C_STALL;
        return C_IDLE;
    endfunction

    function automatic int cap(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Model update at each clock edge (and asynchronously on reset)
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        end else if (!m_err) begin
            if (dmem_busy) begin
                m_busy = m_busy + 1;
                if (m_busy >= TMO) m_err = 1'b1;
            end else begin
                m_busy = 0;
                if (branch_taken)          m_flush = m_flush + 1;
                else if (model_load_use()) m_stall = m_stall + 1;
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        chk("ctl_a", {23'd0, ctl_a}, {23'd0, model_ctl()});
        chk("cnt_a", {a_stall, a_flush}, {cap(m_stall, 65535) & 32'hffff, 16'(cap(m_flush, 65535))} >> 0);
        chk("b", {19'd0, ctl_b, b_stall, b_flush}, {19'd0, model_ctl(), 2'(cap(m_stall, 3)), 2'(cap(m_flush, 3))});
    end

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_memread = 1'b0; branch_taken = 1'b0; dmem_busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hazard_rs1_5();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        branch_taken = 1'b1;            // event during reset must be masked
        tick();
        chk("reset_ctl", {23'd0, ctl_a}, {23'd0, C_IDLE});
        chk("reset_cnt", {a_stall, a_flush}, 32'd0);
        idle();
        tick();
        reset = 1'b0;

        // x0 destination never stalls
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        #1 chk("x0_ctl", {23'd0, ctl_a}, {23'd0, C_IDLE});
        tick(); idle();
        chk("x0_stall_cnt", {16'd0, a_stall}, 32'd0);

        // Basic load-use stall on rs1
        hazard_rs1_5();
        #1 chk("lu_ctl", {23'd0, ctl_a}, {23'd0, C_STALL});
        tick(); idle();
        chk("lu_stall_cnt", {16'd0, a_stall}, 32'd1);
        #1 chk("lu_one_cycle", {23'd0, ctl_a}, {23'd0, C_IDLE});
        tick();

        // rs2 hazard, unused operand, non-load
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        tick();
        id_use_rs2 = 1'b0;
        tick();
        id_use_rs2 = 1'b1; ex_memread = 1'b0;
        tick(); idle();
        chk("rs2_stall_cnt", {16'd0, a_stall}, 32'd2);

        // Branch beats simultaneous load-use
        pulse_reset();
        hazard_rs1_5(); branch_taken = 1'b1;
        #1 chk("br_lu_ctl", {23'd0, ctl_a}, {23'd0, C_BRANCH});
        tick(); idle();
        chk("br_lu_cnt", {a_stall, a_flush}, {16'd0, 16'd1});

        // Busy overrides branch for 3 cycles; branch honoured on release
        branch_taken = 1'b1; dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("busy_ctl", {23'd0, ctl_a}, {23'd0, C_FREEZE});
            tick();
        end
        dmem_busy = 1'b0;
        #1 chk("release_ctl", {23'd0, ctl_a}, {23'd0, C_BRANCH});
        tick(); idle();
        chk("release_flush_cnt", {16'd0, a_flush}, 32'd2);

        // 15 busy cycles: one short of timeout
        dmem_busy = 1'b1;
        for (int i = 0; i < TMO - 1; i++) tick();
        dmem_busy = 1'b0;
        #1 chk("no_timeout", {23'd0, ctl_a}, {23'd0, C_IDLE});
        tick();

        // 16 busy cycles: ERROR from cycle 17, sticky until async reset
        dmem_busy = 1'b1;
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("halt_pre", {31'd0, a_halt}, 32'd0);
        tick();
        chk("halt_set", {31'd0, a_halt}, 32'd1);
        idle();
        for (int i = 0; i < 3; i++) tick();
        chk("error_sticky", {23'd0, ctl_a}, {23'd0, C_ERROR});
        #2 reset = 1'b1;
        #1 chk("async_reset", {23'd0, ctl_a}, {23'd0, C_IDLE});
        tick();
        reset = 1'b0;
        tick();

        // Five stalls: 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            hazard_rs1_5(); tick(); idle(); tick();
        end
        chk("sat_b", {30'd0, b_stall}, 32'd3);
        chk("sat_a", {16'd0, a_stall}, 32'd5);
        hazard_rs1_5(); tick(); idle(); tick();
        chk("sat_b_hold", {30'd0, b_stall}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
